// File: rtl/carregador_programa_pkg.sv
// Shared constants for the program loader: opcodes, mode codes, one-hot bit order, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package carregador_programa_pkg;

    localparam int OP_W    = 18;   // one-hot operation field width
    localparam int MODE_W  = 4;    // one-hot addressing-mode field width
    localparam int OPC_W   = 5;    // encoded opcode width
    localparam int MODEC_W = 2;    // encoded mode width
    localparam int OPND_W  = 9;    // operand width
    localparam int WORD_W  = 16;   // instruction word width

    // Opcodes. The one-hot bit for an operation sits at the index equal to its opcode.
    localparam logic [OPC_W-1:0] OP_NOP = 5'd0,  OP_STA = 5'd1,  OP_LDA = 5'd2,  OP_ADD = 5'd3;
    localparam logic [OPC_W-1:0] OP_SUB = 5'd4,  OP_AND = 5'd5,  OP_OR  = 5'd6,  OP_NOT = 5'd7;
    localparam logic [OPC_W-1:0] OP_J   = 5'd8,  OP_JN  = 5'd9,  OP_JZ  = 5'd10, OP_IN  = 5'd11;
    localparam logic [OPC_W-1:0] OP_OUT = 5'd12, OP_SHR = 5'd13, OP_SHL = 5'd14, OP_HLT = 5'd15;
    localparam logic [OPC_W-1:0] OP_STD = 5'd16, OP_LDD = 5'd17;

    // Mode codes; the one-hot mode bit index equals the mode code.
    localparam logic [MODEC_W-1:0] MODE_DIR = 2'b00, MODE_IND = 2'b01;
    localparam logic [MODEC_W-1:0] MODE_IM  = 2'b10, MODE_SOP = 2'b11;

    // One-hot bit positions used when building stimulus or decoding fields.
    localparam int OPBIT_HLT = 15;
    localparam int MBIT_DIR = 0, MBIT_IND = 1, MBIT_IM = 2, MBIT_SOP = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_FULL = 2'd3
    } state_t;

    function automatic logic [WORD_W-1:0] packWord(input logic [OPC_W-1:0] opc,
                                                   input logic [MODEC_W-1:0] mode,
                                                   input logic [OPND_W-1:0] opnd);
        return {opc, mode, opnd};
    endfunction

endpackage

// File: rtl/carregador_programa_if.sv
// Loader bus bundle: control pulses, instruction field handshake, memory write port, status.
// Latency: n/a (signal bundle).
// Backpressure: in_valid/in_ready; optional chk present when CARREGADOR_CHECKSUM_EN is defined.
// Modports: master = instruction source / status consumer, slave = the loader.
interface carregador_programa_if #(parameter int ADDR_W = 8);
    import carregador_programa_pkg::*;

    logic                  start;
    logic                  abort;
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_W-1:0]       in_op;
    logic [MODE_W-1:0]     in_mode;
    logic [OPND_W-1:0]     in_operand;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [WORD_W-1:0]     mem_data;
    logic                  busy;
    logic                  done;
    logic                  full;
    logic [1:0]            err;
    logic [ADDR_W:0]       count;
`ifdef CARREGADOR_CHECKSUM_EN
    logic [WORD_W-1:0]     chk;
`endif

    modport master (
`ifdef CARREGADOR_CHECKSUM_EN
        input  chk,
`endif
        output start, abort, in_valid, in_op, in_mode, in_operand,
        input  in_ready, mem_we, mem_addr, mem_data, busy, done, full, err, count
    );

    modport slave (
`ifdef CARREGADOR_CHECKSUM_EN
        output chk,
`endif
        input  start, abort, in_valid, in_op, in_mode, in_operand,
        output in_ready, mem_we, mem_addr, mem_data, busy, done, full, err, count
    );

endinterface

// File: rtl/carregador_programa_onehot_enc.sv
// One-hot to binary encoder with an exactly-one-bit-set flag.
// Latency: combinational.
// Backpressure: none.
// Ports: onehot (N) in; idx (W) out = index of set bit; vld out = exactly one bit set.
module onehot_enc #(
    parameter int N = 18,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         vld
);

    logic seen;
    logic multi;

    // OR-ing indices gives the right answer only when one bit is set; vld tells the caller.
    always_comb begin
        idx   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
                idx  = idx | W'(i);
            end
        end
        vld = seen && !multi;
    end

endmodule

// File: rtl/carregador_programa.sv
// Program loader: encodes one-hot op/mode + operand into 16-bit words, writes them sequentially.
// Latency: 1 cycle from accepted fields to mem_we; one word per cycle, no bubbles.
// Backpressure: in_ready high only while loading; drops after HLT, last address or abort.
// Ports: clk, rst_n (async active-low), bus (carregador_programa_if.slave).
// Optional: CARREGADOR_CHECKSUM_EN adds bus.chk, running XOR of written words.
module carregador_programa
    import carregador_programa_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter bit STOP_ON_HLT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    carregador_programa_if.slave bus
);

    state_t state, stateNext;

    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W:0]    countQ;
    logic [1:0]         errQ;
    logic               memWeQ;
    logic [ADDR_W-1:0]  memAddrQ;
    logic [WORD_W-1:0]  memDataQ;

    logic [OPC_W-1:0]   opIdx;
    logic               opOk;
    logic [MODEC_W-1:0] modeIdx;
    logic               modeOk;

    onehot_enc #(.N(OP_W))   uOpEnc   (.onehot(bus.in_op),   .idx(opIdx),   .vld(opOk));
    onehot_enc #(.N(MODE_W)) uModeEnc (.onehot(bus.in_mode), .idx(modeIdx), .vld(modeOk));

    // Malformed fields encode as NOP / DIR so the stored word still decodes cleanly.
    logic [OPC_W-1:0]   opcode;
    logic [MODEC_W-1:0] modeCode;
    logic [WORD_W-1:0]  word;
    assign opcode   = opOk   ? opIdx   : OP_NOP;
    assign modeCode = modeOk ? modeIdx : MODE_DIR;
    assign word     = packWord(opcode, modeCode, bus.in_operand);

    logic loading, xfer, lastAddr, isHlt, loadStart;
    assign loading   = (state == ST_LOAD);
    assign xfer      = loading && bus.in_valid && !bus.abort;   // abort beats a same-cycle transfer
    assign lastAddr  = (ptr == {ADDR_W{1'b1}});
    assign isHlt     = STOP_ON_HLT && (opcode == OP_HLT);
    assign loadStart = !loading && bus.start && !bus.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            ST_LOAD: begin
                if (bus.abort)   stateNext = ST_IDLE;
                else if (xfer) begin
                    if (isHlt)         stateNext = ST_DONE;   // HLT at the last address still ends as DONE
                    else if (lastAddr) stateNext = ST_FULL;
                end
            end
            default: begin
                if (bus.abort)      stateNext = ST_IDLE;
                else if (bus.start) stateNext = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            countQ   <= '0;
            errQ     <= '0;
            memWeQ   <= 1'b0;
            memAddrQ <= '0;
            memDataQ <= '0;
        end else begin
            memWeQ <= xfer;
            if (xfer) begin
                memAddrQ <= ptr;
                memDataQ <= word;
                countQ   <= countQ + 1'b1;
                errQ     <= errQ | {!opOk, !modeOk};
                if (!lastAddr) ptr <= ptr + 1'b1;   // saturate: the pointer never wraps
            end
            if (loadStart) begin
                ptr    <= '0;
                countQ <= '0;
                errQ   <= '0;
            end
        end
    end

`ifdef CARREGADOR_CHECKSUM_EN
    logic [WORD_W-1:0] chkQ;
    // Updated at the same edge that raises mem_we, so chk already includes the word on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       chkQ <= '0;
        else if (loadStart || bus.abort)  chkQ <= '0;
        else if (xfer)                    chkQ <= chkQ ^ word;
    end
    assign bus.chk = chkQ;
`endif

    assign bus.in_ready = loading;
    assign bus.busy     = loading;
    assign bus.done     = (state == ST_DONE);
    assign bus.full     = (state == ST_FULL);
    assign bus.err      = errQ;
    assign bus.count    = countQ;
    assign bus.mem_we   = memWeQ;
    assign bus.mem_addr = memAddrQ;
    assign bus.mem_data = memDataQ;

endmodule

// File: tb/tb_carregador_programa.sv
module tb_carregador_programa;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    carregador_programa_if #(.ADDR_W(8)) ifA ();
    carregador_programa_if #(.ADDR_W(2)) ifB ();

    carregador_programa #(.ADDR_W(8), .STOP_ON_HLT(1'b1)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    carregador_programa #(.ADDR_W(2), .STOP_ON_HLT(1'b1)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

    // Reference model for dutA, kept as flags and counters rather than a state machine.
    bit          mLoading, mDone, mFull, mWe;
    int          mPtr, mCount;
    logic [1:0]  mErr;
    logic [7:0]  mAddr;
    logic [15:0] mData, mChk;

    function automatic logic [15:0] encode(input logic [17:0] op, input logic [3:0] md, input logic [8:0] opd);
        int opc = 0;
        int mc = 0;
        for (int i = 0; i < 18; i++) if (op == (18'd1 << i)) opc = i;
        for (int i = 0; i < 4; i++)  if (md == (4'd1 << i))  mc = i;
        return {opc[4:0], mc[1:0], opd};
    endfunction

    function automatic logic [17:0] rndOp();
        if ($urandom_range(0, 9) < 8) return 18'd1 << $urandom_range(0, 17);
        return 18'($urandom);
    endfunction

    function automatic logic [3:0] rndMode();
        if ($urandom_range(0, 9) < 8) return 4'd1 << $urandom_range(0, 3);
        return 4'($urandom);
    endfunction

    function automatic logic [17:0] rndOpNoHlt();
        int k = $urandom_range(0, 16);
        if (k >= 15) k++;
        return 18'd1 << k;
    endfunction

    task automatic modelReset();
        mLoading = 0; mDone = 0; mFull = 0; mWe = 0;
        mPtr = 0; mCount = 0; mErr = 2'b00; mAddr = '0; mData = '0; mChk = '0;
    endtask

    task automatic modelStep(input bit st, input bit ab, input bit v,
                             input logic [17:0] op, input logic [3:0] md, input logic [8:0] opd);
        logic [15:0] w;
        mWe = 0;
        if (mLoading) begin
            if (ab) begin
                mLoading = 0; mChk = '0;
            end else if (v) begin
                w = encode(op, md, opd);
                mWe = 1; mAddr = 8'(mPtr); mData = w; mCount++; mChk ^= w;
                if ($countones(op) != 1) mErr[1] = 1'b1;
                if ($countones(md) != 1) mErr[0] = 1'b1;
                if (w[15:11] == 5'd15) begin
                    mLoading = 0; mDone = 1;
                end else if (mPtr == 255) begin
                    mLoading = 0; mFull = 1;
                end else begin
                    mPtr++;
                end
            end
        end else if (ab) begin
            mDone = 0; mFull = 0; mChk = '0;
        end else if (st) begin
            mLoading = 1; mDone = 0; mFull = 0; mPtr = 0; mCount = 0; mErr = 2'b00; mChk = '0;
        end
    endtask

    task automatic stepA(input bit st, input bit ab, input bit v,
                         input logic [17:0] op, input logic [3:0] md, input logic [8:0] opd);
        ifA.start = st; ifA.abort = ab; ifA.in_valid = v;
        ifA.in_op = op; ifA.in_mode = md; ifA.in_operand = opd;
        modelStep(st, ab, v, op, md, opd);
        @(posedge clk); #1;
        ifA.start = 1'b0; ifA.abort = 1'b0; ifA.in_valid = 1'b0;
    endtask

    task automatic stepB(input bit st, input bit ab, input bit v,
                         input logic [17:0] op, input logic [3:0] md, input logic [8:0] opd);
        ifB.start = st; ifB.abort = ab; ifB.in_valid = v;
        ifB.in_op = op; ifB.in_mode = md; ifB.in_operand = opd;
        @(posedge clk); #1;
        ifB.start = 1'b0; ifB.abort = 1'b0; ifB.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ifA.in_ready, ifA.busy, ifA.mem_we, ifA.done, ifA.full, ifA.err, ifA.count, ifA.mem_addr, ifA.mem_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: we=%b rdy=%b busy=%b done=%b full=%b err=%b count=%0d addr=%0d data=%h, required all 0",
                     ifA.mem_we, ifA.in_ready, ifA.busy, ifA.done, ifA.full, ifA.err, ifA.count, ifA.mem_addr, ifA.mem_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic test_single();
        stepA(1, 0, 0, '0, '0, '0);
        checks++;
        if ({ifA.in_ready, ifA.busy} !== 2'b11) begin
            failures++; $display("FAIL start_load: rdy=%b busy=%b, required 1 1", ifA.in_ready, ifA.busy);
        end
        stepA(0, 0, 1, 18'd1 << 3, 4'd1 << 2, 9'h05);   // ADD, IM
        checks++;
        if ({ifA.mem_we, ifA.mem_addr, ifA.mem_data, ifA.count} !== {1'b1, 8'd0, 16'h1C05, 9'd1}) begin
            failures++;
            $display("FAIL single_write: we=%b addr=%0d data=%h count=%0d, required 1 0 1c05 1",
                     ifA.mem_we, ifA.mem_addr, ifA.mem_data, ifA.count);
        end
        stepA(0, 1, 0, '0, '0, '0);
        checks++;
        if ({ifA.in_ready, ifA.busy, ifA.mem_we} !== 3'b000) begin
            failures++; $display("FAIL abort_idle: rdy=%b busy=%b we=%b, required 0 0 0", ifA.in_ready, ifA.busy, ifA.mem_we);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] op;
        logic [3:0]  md;
        logic [8:0]  opd;
        stepA(1, 0, 0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            op = rndOpNoHlt(); md = 4'd1 << $urandom_range(0, 3); opd = 9'($urandom);
            stepA(0, 0, 1, op, md, opd);
            checks++;
            if ({ifA.mem_we, ifA.mem_addr, ifA.mem_data, ifA.count} !== {1'b1, 8'(i), encode(op, md, opd), 9'(i + 1)}) begin
                failures++;
                $display("FAIL b2b_write%0d: we=%b addr=%0d data=%h count=%0d, required 1 %0d %h %0d",
                         i, ifA.mem_we, ifA.mem_addr, ifA.mem_data, ifA.count, i, encode(op, md, opd), i + 1);
            end
        end
        stepA(0, 0, 1, 18'd1 << 2, 4'd1 << 1, 9'h1FF);   // LDA, IND
        checks++;
        if ({ifA.mem_we, ifA.mem_addr, ifA.mem_data} !== {1'b1, 8'd3, 16'h13FF}) begin
            failures++;
            $display("FAIL lda_ind: we=%b addr=%0d data=%h, required 1 3 13ff", ifA.mem_we, ifA.mem_addr, ifA.mem_data);
        end
        stepA(0, 0, 1, 18'd1 << 15, 4'd1 << 3, 9'h000);  // HLT, SOP
        checks++;
        if ({ifA.mem_we, ifA.mem_addr, ifA.mem_data, ifA.done, ifA.in_ready, ifA.count} !==
            {1'b1, 8'd4, 16'h7E00, 1'b1, 1'b0, 9'd5}) begin
            failures++;
            $display("FAIL hlt_done: we=%b addr=%0d data=%h done=%b rdy=%b count=%0d, required 1 4 7e00 1 0 5",
                     ifA.mem_we, ifA.mem_addr, ifA.mem_data, ifA.done, ifA.in_ready, ifA.count);
        end
        stepA(0, 0, 1, rndOpNoHlt(), 4'd1, 9'h0AA);
        checks++;
        if ({ifA.mem_we, ifA.done} !== 2'b01) begin
            failures++; $display("FAIL done_no_write: we=%b done=%b, required 0 1", ifA.mem_we, ifA.done);
        end
    endtask

    task automatic test_errors();
        logic [17:0] op;
        stepA(1, 0, 0, '0, '0, '0);   // restart from DONE
        checks++;
        if ({ifA.done, ifA.err, ifA.count, ifA.busy} !== {1'b0, 2'b00, 9'd0, 1'b1}) begin
            failures++;
            $display("FAIL restart_clear: done=%b err=%b count=%0d busy=%b, required 0 00 0 1", ifA.done, ifA.err, ifA.count, ifA.busy);
        end
        stepA(0, 0, 1, 18'd0, 4'd1 << 2, 9'h011);
        checks++;
        if ({ifA.mem_we, ifA.mem_data, ifA.err} !== {1'b1, 16'h0411, 2'b10}) begin
            failures++;
            $display("FAIL zero_op: we=%b data=%h err=%b, required 1 0411 10", ifA.mem_we, ifA.mem_data, ifA.err);
        end
        stepA(0, 0, 1, 18'h00003, 4'h0, 9'h155);
        checks++;
        if ({ifA.mem_we, ifA.mem_data[15:9], ifA.err} !== {1'b1, 7'd0, 2'b11}) begin
            failures++;
            $display("FAIL multi_op_zero_mode: we=%b data=%h err=%b, required 1 opcode0/mode0 err 11", ifA.mem_we, ifA.mem_data, ifA.err);
        end
        op = rndOpNoHlt();
        stepA(0, 0, 1, op, 4'd1, 9'h003);
        checks++;
        if ({ifA.mem_data, ifA.err} !== {encode(op, 4'd1, 9'h003), 2'b11}) begin
            failures++;
            $display("FAIL err_sticky: data=%h err=%b, required %h 11", ifA.mem_data, ifA.err, encode(op, 4'd1, 9'h003));
        end
        stepA(0, 1, 0, '0, '0, '0);
        stepA(1, 0, 0, '0, '0, '0);
        checks++;
        if (ifA.err !== 2'b00) begin
            failures++; $display("FAIL err_clear_on_start: err=%b, required 00", ifA.err);
        end
    endtask

    task automatic test_reset_mid_load();
        stepA(0, 0, 1, 18'd1 << 4, 4'd1, 9'h021);   // mem_we is now high
        ifA.in_valid = 1'b1; ifA.in_op = 18'd1 << 5; ifA.in_mode = 4'd1; ifA.in_operand = 9'h042;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ifA.in_ready, ifA.busy, ifA.mem_we, ifA.done, ifA.full, ifA.err, ifA.count, ifA.mem_addr, ifA.mem_data} !== '0) begin
            failures++;
            $display("FAIL async_reset: we=%b rdy=%b busy=%b count=%0d addr=%0d data=%h, required all 0",
                     ifA.mem_we, ifA.in_ready, ifA.busy, ifA.count, ifA.mem_addr, ifA.mem_data);
        end
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ifA.in_ready, ifA.busy, ifA.mem_we} !== 3'b000) begin
            failures++; $display("FAIL idle_after_reset: rdy=%b busy=%b we=%b, required 0 0 0", ifA.in_ready, ifA.busy, ifA.mem_we);
        end
        ifA.in_valid = 1'b0;
    endtask

    task automatic test_random();
        bit st, ab, v;
        for (int n = 0; n < 400; n++) begin
            st = ($urandom_range(0, 99) < 8);
            ab = ($urandom_range(0, 99) < 4);
            v  = ($urandom_range(0, 99) < 70);
            stepA(st, ab, v, rndOp(), rndMode(), 9'($urandom));
            checks++;
            if ({ifA.in_ready, ifA.busy, ifA.mem_we, ifA.done, ifA.full, ifA.err, ifA.count} !==
                {mLoading, mLoading, mWe, mDone, mFull, mErr, 9'(mCount)}) begin
                failures++;
                $display("FAIL rand_status%0d: rdy=%b we=%b done=%b full=%b err=%b count=%0d, required %b %b %b %b %b %0d",
                         n, ifA.in_ready, ifA.mem_we, ifA.done, ifA.full, ifA.err, ifA.count,
                         mLoading, mWe, mDone, mFull, mErr, mCount);
            end
            if (mWe) begin
                checks++;
                if ({ifA.mem_addr, ifA.mem_data} !== {mAddr, mData}) begin
                    failures++;
                    $display("FAIL rand_word%0d: addr=%0d data=%h, required %0d %h", n, ifA.mem_addr, ifA.mem_data, mAddr, mData);
                end
            end
`ifdef CARREGADOR_CHECKSUM_EN
            checks++;
            if (ifA.chk !== mChk) begin
                failures++; $display("FAIL rand_chk%0d: chk=%h, required %h", n, ifA.chk, mChk);
            end
`endif
        end
    endtask

    task automatic test_full();
        stepB(1, 0, 0, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            stepB(0, 0, 1, rndOpNoHlt(), 4'd1 << 1, 9'(i));
            checks++;
            if ({ifB.mem_we, ifB.mem_addr, ifB.full, ifB.count} !== {1'b1, 2'(i), (i == 3), 3'(i + 1)}) begin
                failures++;
                $display("FAIL full_write%0d: we=%b addr=%0d full=%b count=%0d, required 1 %0d %0d %0d",
                         i, ifB.mem_we, ifB.mem_addr, ifB.full, ifB.count, i, i == 3, i + 1);
            end
        end
        stepB(0, 0, 1, rndOpNoHlt(), 4'd1, 9'h0);
        checks++;
        if ({ifB.mem_we, ifB.in_ready, ifB.full, ifB.count} !== {1'b0, 1'b0, 1'b1, 3'd4}) begin
            failures++;
            $display("FAIL full_no_write: we=%b rdy=%b full=%b count=%0d, required 0 0 1 4", ifB.mem_we, ifB.in_ready, ifB.full, ifB.count);
        end
    endtask

    task automatic test_abort_with_valid();
        stepB(1, 0, 0, '0, '0, '0);   // restart from FULL
        checks++;
        if ({ifB.full, ifB.busy, ifB.count} !== {1'b0, 1'b1, 3'd0}) begin
            failures++; $display("FAIL full_restart: full=%b busy=%b count=%0d, required 0 1 0", ifB.full, ifB.busy, ifB.count);
        end
        stepB(0, 1, 1, 18'd1 << 3, 4'd1, 9'h07);
        checks++;
        if ({ifB.mem_we, ifB.busy, ifB.in_ready, ifB.count} !== {1'b0, 1'b0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL abort_beats_valid: we=%b busy=%b rdy=%b count=%0d, required 0 0 0 0", ifB.mem_we, ifB.busy, ifB.in_ready, ifB.count);
        end
        stepB(0, 0, 1, 18'd1 << 3, 4'd1, 9'h07);
        checks++;
        if ({ifB.mem_we, ifB.busy} !== 2'b00) begin
            failures++; $display("FAIL idle_ignores_valid: we=%b busy=%b, required 0 0", ifB.mem_we, ifB.busy);
        end
    endtask

    initial begin
        ifA.start = 0; ifA.abort = 0; ifA.in_valid = 0; ifA.in_op = '0; ifA.in_mode = '0; ifA.in_operand = '0;
        ifB.start = 0; ifB.abort = 0; ifB.in_valid = 0; ifB.in_op = '0; ifB.in_mode = '0; ifB.in_operand = '0;
        modelReset();
        test_reset();
        test_single();
        test_back_to_back();
        test_errors();
        test_reset_mid_load();
        test_random();
        test_full();
        test_abort_with_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
